// File: rtl/dw_conv_pkg.sv
// dw_conv_pkg: shared FSM/activation types and config address map for dw_conv_seq
package dw_conv_pkg;
  typedef enum logic [1:0] {IDLE, MAC, RQ, OUT} state_t;
  typedef enum logic [1:0] {AM_SAT, AM_RELU, AM_CLIP, AM_RSVD} act_mode_t;
  localparam int W_BASE = 0;
  function automatic int bias_base(input int ch, input int ktaps);
    return ch * ktaps;
  endfunction
endpackage

// File: rtl/dw_requant.sv
// dw_requant: bias add, arithmetic shift and activation for one MAC lane
module dw_requant import dw_conv_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int FRAC     = 15,
  parameter int CLIP_MAX = 6
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [ACC_W-1:0]  bias,
  input  act_mode_t                mode,
  output logic signed [DATA_W-1:0] res
);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] CLIPV = ACC_W'(CLIP_MAX);
  logic signed [ACC_W-1:0] sum, s, sat, pos;
  always_comb begin
    sum = acc + bias;
    s   = sum >>> FRAC;
    sat = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
    pos = (mode == AM_RELU) ? ((s > MAXV) ? MAXV : s) : ((s > CLIPV) ? CLIPV : s);
    res = (mode == AM_SAT) ? DATA_W'(sat) : s[ACC_W-1] ? '0 : DATA_W'(pos);
  end
endmodule

// File: rtl/dw_conv_seq.sv
// dw_conv_seq: time-multiplexed depthwise KxK convolution with loadable weights/biases
module dw_conv_seq import dw_conv_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int CH       = 8,
  parameter int LANES    = 2,
  parameter int KTAPS    = 9,
  parameter int FRAC     = 15,
  parameter int CLIP_MAX = 6,
  localparam int AW      = $clog2(CH*KTAPS+CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*KTAPS*DATA_W-1:0] in_act,
  input  logic [1:0]                 act_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH*DATA_W-1:0]       out_act,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [ACC_W-1:0]           cfg_wdata,
  output logic                       cfg_err
);
  localparam int NG = CH / LANES;
  localparam int NW = CH * KTAPS;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int TW = KTAPS > 1 ? $clog2(KTAPS) : 1;
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  state_t state;
  act_mode_t mode_r;
  logic [GW-1:0] grp;
  logic [TW-1:0] tap;
  logic signed [DATA_W-1:0] x_r [NW];
  logic signed [DATA_W-1:0] w [NW];
  logic signed [ACC_W-1:0] b [CH];
  logic [DATA_W-1:0] o_r [CH];
  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [DATA_W-1:0] res [LANES];
  logic [CW-1:0] lc [LANES];
  logic cfg_hit, cfg_is_w;
  assign cfg_hit  = cfg_we && ({1'b0, cfg_addr} < (AW+1)'(NW + CH));
  assign cfg_is_w = {1'b0, cfg_addr} < (AW+1)'(NW);
  for (genvar c = 0; c < CH; c++) begin : g_out
    assign out_act[c*DATA_W +: DATA_W] = o_r[c];
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0] wi;
    logic signed [2*DATA_W-1:0] p;
    always_comb begin
      lc[l]   = CW'(int'(grp) * LANES + l);
      wi      = IW'(int'(lc[l]) * KTAPS + int'(tap));
      p       = x_r[wi] * w[wi];
      prod[l] = ACC_W'(p);
    end
    dw_requant #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC), .CLIP_MAX(CLIP_MAX)) u_rq (
      .acc(acc[l]), .bias(b[lc[l]]), .mode(mode_r), .res(res[l])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      mode_r    <= AM_SAT;
      grp       <= '0;
      tap       <= '0;
      for (int i = 0; i < NW; i++) begin
        w[i]   <= '0;
        x_r[i] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        b[i]   <= '0;
        o_r[i] <= '0;
      end
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      cfg_err <= cfg_hit && state != IDLE;
      // writes land in IDLE only, so a job never sees its coefficients change mid-flight
      if (cfg_hit && state == IDLE) begin
        if (cfg_is_w) w[IW'(cfg_addr - AW'(W_BASE))] <= cfg_wdata[DATA_W-1:0];
        else b[CW'(cfg_addr - AW'(bias_base(CH, KTAPS)))] <= cfg_wdata;
      end
      case (state)
        IDLE: if (in_valid) begin
          state    <= MAC;
          in_ready <= 1'b0;
          mode_r   <= act_mode_t'(act_mode);
          grp      <= '0;
          tap      <= '0;
          for (int i = 0; i < NW; i++) x_r[i] <= in_act[i*DATA_W +: DATA_W];
          for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end
        MAC: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + prod[l];
          tap   <= tap + 1'b1;
          state <= (tap == TW'(KTAPS-1)) ? RQ : MAC;
        end
        RQ: begin
          for (int l = 0; l < LANES; l++) begin
            o_r[lc[l]] <= res[l];
            acc[l]     <= '0;
          end
          tap <= '0;
          if (grp == GW'(NG-1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end else begin
            grp   <= grp + 1'b1;
            state <= MAC;
          end
        end
        OUT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dw_conv_seq.sv
// tb_dw_conv_seq: scoreboard bench with an arithmetic reference model for dw_conv_seq
module tb_dw_conv_seq;
  localparam int DW = 16, CH = 8, LN = 2, KT = 9, FRAC = 15, CLIP = 6;
  localparam int LAT = (CH / LN) * (KT + 1);
  localparam int CAW = $clog2(CH*KT+CH);
  localparam int OW = CH * DW;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, cfg_we = 0, cfg_err;
  logic [CH*KT*DW-1:0] in_act = '0;
  logic [1:0] act_mode = 0;
  logic [OW-1:0] out_act;
  logic [CAW-1:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  int total = 0, bad = 0, cyc = 0;
  int wm [CH][KT];
  int bm [CH];
  int xm [CH][KT];
  typedef struct {logic [OW-1:0] d; int due;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dw_conv_seq #(.DATA_W(DW), .ACC_W(32), .CH(CH), .LANES(LN), .KTAPS(KT), .FRAC(FRAC), .CLIP_MAX(CLIP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .act_mode(act_mode), .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err)
  );

  task automatic chk(string nm, logic [OW-1:0] got, logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cyc %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] act_fn(int s, int mode);
    int r;
    if (mode == 0) r = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    else if (s < 0) r = 0;
    else if (mode == 1) r = (s > 32767) ? 32767 : s;
    else r = (s > CLIP) ? CLIP : s;
    return r[DW-1:0];
  endfunction

  function automatic logic [OW-1:0] model(int mode);
    logic [OW-1:0] o;
    int acc;
    o = '0;
    for (int c = 0; c < CH; c++) begin
      acc = bm[c];
      for (int t = 0; t < KT; t++) acc += wm[c][t] * xm[c][t];
      o[c*DW +: DW] = act_fn(acc >>> FRAC, mode);
    end
    return o;
  endfunction

  function automatic int sext16(int v);
    logic signed [15:0] lo;
    lo = v[15:0];
    return int'(lo);
  endfunction

  task automatic cfg_write(int addr, int data);
    @(negedge clk);
    cfg_we = 1; cfg_addr = CAW'(addr); cfg_wdata = data;
    if (addr < CH*KT) wm[addr/KT][addr%KT] = sext16(data);
    else if (addr < CH*KT+CH) bm[addr-CH*KT] = data;
    @(negedge clk);
    cfg_we = 0;
    chk("cfg_err_idle", OW'(cfg_err), '0);
  endtask

  task automatic load_all(int wv, int bv);
    for (int a = 0; a < CH*KT; a++) cfg_write(a, wv);
    for (int c = 0; c < CH; c++) cfg_write(CH*KT + c, bv);
  endtask

  task automatic fill_x(int v);
    for (int c = 0; c < CH; c++) for (int t = 0; t < KT; t++) xm[c][t] = v;
  endtask

  task automatic run_job(int mode);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
      return;
    end
    for (int c = 0; c < CH; c++) for (int t = 0; t < KT; t++) in_act[(c*KT+t)*DW +: DW] = xm[c][t][DW-1:0];
    act_mode = 2'(mode);
    in_valid = 1;
    sb.push_back('{model(mode), cyc + 1 + LAT});
    @(negedge clk);
    in_valid = 0;
    chk("in_ready_drop", OW'(in_ready), '0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin @(negedge clk); n++; end
    total++;
    if (n >= 400) begin bad++; $display("FAIL drain_timeout got=%0d pending exp=0", sb.size()); end
  endtask

  initial begin : monitor
    logic pv, hold;
    logic [OW-1:0] held;
    exp_t e;
    pv = 0; hold = 0; held = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin pv = 0; hold = 0; continue; end
      if (out_valid && !pv) begin
        if (sb.size() == 0) chk("spurious_out_valid", OW'(out_valid), '0);
        else chk("latency", OW'(cyc), OW'(sb[0].due));
      end
      if (out_valid && hold) chk("hold_stable", out_act, held);
      if (out_valid) chk("in_ready_in_out", OW'(in_ready), '0);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", out_act, e.d);
      end
      hold = out_valid && !out_ready;
      held = out_act;
      pv = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int c = 0; c < CH; c++) begin
      bm[c] = 0;
      for (int t = 0; t < KT; t++) wm[c][t] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    chk("rst_out_valid", OW'(out_valid), '0);
    chk("rst_out_act", out_act, '0);
    chk("rst_cfg_err", OW'(cfg_err), '0);

    load_all(16384, 0);
    fill_x(2);
    run_job(2); wait_done();
    run_job(1); wait_done();
    run_job(3); wait_done();
    fill_x(-2);
    run_job(0); wait_done();
    run_job(1); wait_done();
    fill_x(2);
    cfg_write(CH*KT + 3, -294912);
    run_job(0); wait_done();
    cfg_write(100, 12345);
    cfg_write(CH*KT + 3, 0);

    load_all(32767, 0);
    fill_x(32767);
    run_job(0); wait_done();
    for (int a = 0; a < CH*KT; a++) if (a % KT != 0) cfg_write(a, 0);
    run_job(0); wait_done();

    // backpressure and dropped config write during MAC
    load_all(16384, 0);
    fill_x(2);
    out_ready = 0;
    run_job(1);
    cfg_we = 1; cfg_addr = CAW'(0); cfg_wdata = 999;
    @(negedge clk);
    cfg_we = 0;
    chk("cfg_err_pulse", OW'(cfg_err), OW'(1));
    @(negedge clk);
    chk("cfg_err_clear", OW'(cfg_err), '0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid", OW'(out_valid), OW'(1));
    repeat (20) @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    chk("release_in_ready", OW'(in_ready), OW'(1));
    chk("release_out_valid", OW'(out_valid), '0);
    wait_done();

    // abort by reset while grp=1 is in MAC
    run_job(1);
    repeat (13) @(negedge clk);
    rst = 1;
    sb.delete();
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < CH; c++) begin
      bm[c] = 0;
      for (int t = 0; t < KT; t++) wm[c][t] = 0;
    end
    @(negedge clk);
    chk("abort_in_ready", OW'(in_ready), OW'(1));
    chk("abort_out_valid", OW'(out_valid), '0);
    repeat (50) @(negedge clk);
    run_job(0); wait_done();

    for (int j = 0; j < 6; j++) begin
      for (int a = 0; a < CH*KT; a++) cfg_write(a, int'($urandom_range(0, 65535)));
      for (int c = 0; c < CH; c++) cfg_write(CH*KT + c, int'($urandom_range(0, 1 << 21)) - (1 << 20));
      for (int c = 0; c < CH; c++) for (int t = 0; t < KT; t++) xm[c][t] = int'($urandom_range(0, 65535)) - 32768;
      run_job(int'($urandom_range(0, 3)));
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
